music_sequencer: RTL and testbench

- Plays a two-voice score stored in an external synchronous ROM.
- Fetches one score word per note, translates the left and right note codes into half-period divider values, and holds them for the note's duration.
- Inserts a short articulation gap after each note.
- Drives the note_div_left/note_div_right inputs of the square-wave note generator.
- Accepts play/pause/stop control pulses from the board UI logic.

---
 rtl/music_pkg.sv | 55 +++++
 rtl/note_div_lut.sv | 19 +
 rtl/music_sequencer.sv | 177 +++++++++++++++++
 tb/tb_music_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared types and constants for the two-voice score sequencer:
// FSM states, score word layout and the note-code to half-period divider table.
package music_pkg;

    localparam int DIV_W      = 22;
    localparam logic [DIV_W-1:0] DIV_SILENT = 22'd1;
    localparam int NOTE_CODES = 48;

    localparam int WORD_W    = 17;
    localparam int END_BIT   = 16;
    localparam int DUR_MSB   = 15;
    localparam int DUR_LSB   = 12;
    localparam int LEFT_MSB  = 11;
    localparam int LEFT_LSB  = 6;
    localparam int RIGHT_MSB = 5;
    localparam int RIGHT_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PLAY,
        S_GAP,
        S_PAUSED
    } state_t;

    // Octave-3 equal-temperament frequencies in micro-hertz; higher octaves are exact doublings.
    function automatic longint base_uhz(input int semi);
        case (semi)
            0:       return 64'd130812783;
            1:       return 64'd138591315;
            2:       return 64'd146832384;
            3:       return 64'd155563492;
            4:       return 64'd164813778;
            5:       return 64'd174614116;
            6:       return 64'd184997211;
            7:       return 64'd195997718;
            8:       return 64'd207652349;
            9:       return 64'd220000000;
            10:      return 64'd233081881;
            default: return 64'd246941651;
        endcase
    endfunction

    // Half-period in clk cycles truncated to an integer, minus one; codes outside 1..48 are silent.
    function automatic logic [DIV_W-1:0] note_div(input int code, input longint clk_hz);
        longint f_uhz;
        longint half;
        if (code < 1 || code > NOTE_CODES) return DIV_SILENT;
        f_uhz = base_uhz((code - 1) % 12) << ((code - 1) / 12);
        half  = (clk_hz * 64'd1000000) / (64'd2 * f_uhz);
        return DIV_W'(half - 64'd1);
    endfunction

endpackage

// File: rtl/note_div_lut.sv
// Combinational note-code to divider lookup; the table is built at elaboration.
module note_div_lut
    import music_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic [5:0]       code,
    output logic [DIV_W-1:0] div
);

    logic [DIV_W-1:0] div_rom [64];

    for (genvar g = 0; g < 64; g++) begin : g_rom
        assign div_rom[g] = note_div(g, longint'(CLK_HZ));
    end

    assign div = div_rom[code];

endmodule

// File: rtl/music_sequencer.sv
// Two-voice score player: fetches one ROM word per note, holds the dividers for the
// note duration, then silences both voices for a short articulation gap.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | stopped at address 0, outputs silent
// S_FETCH  | ROM is addressing the current score word
// S_WAIT   | score word decoded: start note, loop back, or finish
// S_PLAY   | dividers driven, down-counter runs the sounding part
// S_GAP    | dividers silent, down-counter runs the articulation gap
// S_PAUSED | silent, counter and saved dividers frozen until play
module music_sequencer
    import music_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned TICK_CYCLES = 6_250_000,
    parameter int unsigned GAP_CYCLES  = 500_000,
    parameter int unsigned SCORE_LEN   = 512,
    parameter int unsigned ADDR_W      = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play,
    input  logic              pause,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    output logic [DIV_W-1:0]  note_div_left,
    output logic [DIV_W-1:0]  note_div_right,
    output logic              busy,
    output logic              note_strobe,
    output logic              done
);

    localparam int CNT_W = $clog2(16 * TICK_CYCLES + 1);
    localparam logic [CNT_W-1:0]  TICK_C    = CNT_W'(TICK_CYCLES);
    localparam logic [CNT_W-1:0]  GAP_PLUS1 = CNT_W'(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SCORE_LEN - 1);

    state_t state, state_nxt;
    state_t saved_state, saved_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DIV_W-1:0]  div_l_q, div_r_q, div_l_nxt, div_r_nxt;
    logic [DIV_W-1:0]  lut_left, lut_right;
    logic              strobe_nxt, done_nxt;
    logic [3:0]        dur_field;
    logic [4:0]        dur;
    logic [CNT_W-1:0]  play_last;

    note_div_lut #(.CLK_HZ(CLK_HZ)) u_lut_left (
        .code (rom_data[LEFT_MSB:LEFT_LSB]),
        .div  (lut_left)
    );

    note_div_lut #(.CLK_HZ(CLK_HZ)) u_lut_right (
        .code (rom_data[RIGHT_MSB:RIGHT_LSB]),
        .div  (lut_right)
    );

    assign dur_field = rom_data[DUR_MSB:DUR_LSB];
    assign dur       = (dur_field == 4'd0) ? 5'd16 : {1'b0, dur_field};
    // Sounding cycles minus one: the gap is carved out of the note's own duration.
    assign play_last = CNT_W'(dur) * TICK_C - GAP_PLUS1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            saved_state <= S_PLAY;
            cnt         <= '0;
            rom_addr    <= '0;
            div_l_q     <= DIV_SILENT;
            div_r_q     <= DIV_SILENT;
            note_strobe <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            saved_state <= saved_nxt;
            cnt         <= cnt_nxt;
            rom_addr    <= addr_nxt;
            div_l_q     <= div_l_nxt;
            div_r_q     <= div_r_nxt;
            note_strobe <= strobe_nxt;
            done        <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        saved_nxt  = saved_state;
        cnt_nxt    = cnt;
        addr_nxt   = rom_addr;
        div_l_nxt  = div_l_q;
        div_r_nxt  = div_r_q;
        strobe_nxt = 1'b0;
        done_nxt   = 1'b0;

        if (stop) begin
            state_nxt = S_IDLE;
            addr_nxt  = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (play && !pause) begin
                        state_nxt = S_FETCH;
                        addr_nxt  = '0;
                    end
                end
                S_FETCH: state_nxt = S_WAIT;
                S_WAIT: begin
                    if (!rom_data[END_BIT]) begin
                        div_l_nxt  = lut_left;
                        div_r_nxt  = lut_right;
                        strobe_nxt = 1'b1;
                        cnt_nxt    = play_last;
                        state_nxt  = S_PLAY;
                    end else begin
                        addr_nxt = '0;
                        if (loop_en) begin
                            state_nxt = S_FETCH;
                        end else begin
                            done_nxt  = 1'b1;
                            state_nxt = S_IDLE;
                        end
                    end
                end
                S_PLAY: begin
                    if (cnt == '0) begin
                        cnt_nxt   = GAP_LAST;
                        state_nxt = S_GAP;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                    // The pause cycle still counts; resuming lands where playback would have been.
                    if (pause) begin
                        saved_nxt = state_nxt;
                        state_nxt = S_PAUSED;
                    end
                end
                S_GAP: begin
                    if (cnt == '0) begin
                        if (rom_addr == ADDR_LAST) begin
                            addr_nxt = '0;
                            if (loop_en) begin
                                state_nxt = S_FETCH;
                            end else begin
                                done_nxt  = 1'b1;
                                state_nxt = S_IDLE;
                            end
                        end else begin
                            addr_nxt  = rom_addr + ADDR_W'(1);
                            state_nxt = S_FETCH;
                        end
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                        if (pause) begin
                            saved_nxt = S_GAP;
                            state_nxt = S_PAUSED;
                        end
                    end
                end
                S_PAUSED: begin
                    if (play && !pause) state_nxt = saved_state;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign note_div_left  = (state == S_PLAY) ? div_l_q : DIV_SILENT;
    assign note_div_right = (state == S_PLAY) ? div_r_q : DIV_SILENT;
    assign busy           = (state != S_IDLE);

endmodule

// File: tb/tb_music_sequencer.sv
// Self-checking bench for music_sequencer with a scoreboard of expected note/done events.
module tb_music_sequencer;

    localparam int TICK = 10;
    localparam int GAP  = 2;
    localparam int LEN  = 8;
    localparam int AW   = 3;

    localparam logic [21:0] D_A3  = 22'd227271;
    localparam logic [21:0] D_A4  = 22'd113635;
    localparam logic [21:0] D_A5  = 22'd56817;
    localparam logic [21:0] D_A6  = 22'd28408;
    localparam logic [21:0] D_SIL = 22'd1;

    logic          clk = 0, rst = 0, play = 0, pause = 0, stop = 0, loop_en = 0;
    logic [AW-1:0] rom_addr;
    logic [16:0]   rom_data;
    logic [21:0]   left, right;
    logic          busy, note_strobe, done;
    logic [16:0]   rom [LEN];

    int cyc = 0, total = 0, bad = 0;

    typedef struct { int cyc; logic [21:0] l; logic [21:0] r; } strobe_t;
    typedef struct { logic [16:0] word; int len; logic [21:0] l; logic [21:0] r; } vec_t;

    strobe_t strobe_q[$];
    int      done_q[$];
    strobe_t exp_s;
    int      exp_d;
    vec_t    vecs[4];
    int      tt[4];

    music_sequencer #(
        .CLK_HZ(100_000_000), .TICK_CYCLES(TICK), .GAP_CYCLES(GAP),
        .SCORE_LEN(LEN), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop), .loop_en(loop_en),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .note_div_left(left), .note_div_right(right),
        .busy(busy), .note_strobe(note_strobe), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rom_data <= rom[rom_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [16:0] mkword(input logic e, input logic [3:0] d,
                                           input logic [5:0] l, input logic [5:0] r);
        return {e, d, l, r};
    endfunction

    always @(negedge clk) begin
        if (!rst && note_strobe) begin
            check("strobe_expected", strobe_q.size() > 0, 1);
            if (strobe_q.size() > 0) begin
                exp_s = strobe_q.pop_front();
                check("strobe_cycle", cyc, exp_s.cyc);
                check("strobe_left", left, exp_s.l);
                check("strobe_right", right, exp_s.r);
            end
        end
        if (!rst && done) begin
            check("done_expected", done_q.size() > 0, 1);
            if (done_q.size() > 0) begin
                exp_d = done_q.pop_front();
                check("done_cycle", cyc, exp_d);
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample_at(input int c);
        wait_cyc(c);
        @(negedge clk);
    endtask

    task automatic pulse(input int c, input logic p, input logic ps, input logic s);
        wait_cyc(c);
        play = p; pause = ps; stop = s;
        @(posedge clk);
        #1;
        play = 0; pause = 0; stop = 0;
    endtask

    task automatic end_scenario(input string name);
        check({name, "_pending_strobes"}, strobe_q.size(), 0);
        check({name, "_pending_done"}, done_q.size(), 0);
        strobe_q.delete();
        done_q.delete();
    endtask

    task automatic clear_rom();
        for (int i = 0; i < LEN; i++) rom[i] = mkword(1'b1, 4'd0, 6'd0, 6'd0);
    endtask

    initial begin
        int p, t, s, q, tb1;

        clear_rom();
        #1 rst = 1;
        #1;
        check("rst_addr", rom_addr, 0);
        check("rst_left", left, D_SIL);
        check("rst_right", right, D_SIL);
        check("rst_busy", busy, 0);
        check("rst_strobe", note_strobe, 0);
        check("rst_done", done, 0);
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // Table-driven score: A3 over rest, dur 1, dur 0 (=16), out-of-range codes
        vecs[0] = '{mkword(1'b0, 4'd2, 6'd10, 6'd0),  2,  D_A3,  D_SIL};
        vecs[1] = '{mkword(1'b0, 4'd1, 6'd22, 6'd34), 1,  D_A4,  D_A5};
        vecs[2] = '{mkword(1'b0, 4'd0, 6'd46, 6'd49), 16, D_A6,  D_SIL};
        vecs[3] = '{mkword(1'b0, 4'd3, 6'd63, 6'd22), 3,  D_SIL, D_A4};
        clear_rom();
        for (int i = 0; i < 4; i++) rom[i] = vecs[i].word;
        loop_en = 0;
        p = cyc + 2;
        t = p + 3;
        for (int i = 0; i < 4; i++) begin
            tt[i] = t;
            strobe_q.push_back('{t, vecs[i].l, vecs[i].r});
            t += vecs[i].len * TICK + 2;
        end
        done_q.push_back(t);
        pulse(p, 1, 0, 0);
        sample_at(tt[0] + 17);
        check("s1_left_held", left, D_A3);
        check("s1_busy", busy, 1);
        sample_at(tt[0] + 18);
        check("s1_gap_left", left, D_SIL);
        sample_at(tt[0] + 19);
        check("s1_gap_left_end", left, D_SIL);
        check("s1_gap_right_end", right, D_SIL);
        sample_at(tt[2] + 157);
        check("s2_dur16_held", left, D_A6);
        sample_at(tt[2] + 158);
        check("s2_dur16_gap", left, D_SIL);
        sample_at(t);
        check("s1_done_busy", busy, 0);
        check("s1_done_addr", rom_addr, 0);
        sample_at(t + 2);
        end_scenario("table");

        // Looping 3-word score, then stop+pause together during PLAY
        clear_rom();
        rom[0] = mkword(1'b0, 4'd1, 6'd22, 6'd0);
        rom[1] = mkword(1'b0, 4'd2, 6'd34, 6'd22);
        loop_en = 1;
        p = cyc + 2;
        t = p + 3;
        tb1 = 0;
        for (int it = 0; it < 2; it++) begin
            strobe_q.push_back('{t, D_A4, D_SIL});
            t += 12;
            strobe_q.push_back('{t, D_A5, D_A4});
            tb1 = t;
            t += 24;
        end
        pulse(p, 1, 0, 0);
        sample_at(tb1 - 36 + 21);
        check("loop_end_addr", rom_addr, 2);
        sample_at(tb1 - 36 + 22);
        check("loop_restart_addr", rom_addr, 0);
        check("loop_busy", busy, 1);
        sample_at(tb1 + 3);
        check("stop_pre_addr", rom_addr, 1);
        pulse(tb1 + 3, 0, 1, 1);
        sample_at(tb1 + 4);
        check("stop_busy", busy, 0);
        check("stop_addr", rom_addr, 0);
        check("stop_left", left, D_SIL);
        check("stop_right", right, D_SIL);
        check("stop_no_done", done, 0);
        sample_at(tb1 + 40);
        end_scenario("loop_stop");
        loop_en = 0;

        // Pause 5 cycles into PLAY, hold 50 cycles, resume with 13 cycles left
        clear_rom();
        rom[0] = mkword(1'b0, 4'd2, 6'd22, 6'd34);
        p = cyc + 2;
        s = p + 3;
        q = s + 54;
        strobe_q.push_back('{s, D_A4, D_A5});
        done_q.push_back(q + 18);
        pulse(p, 1, 0, 0);
        pulse(p + 1, 0, 1, 0);
        sample_at(s + 4);
        check("pause_pre_left", left, D_A4);
        pulse(s + 4, 0, 1, 0);
        sample_at(s + 5);
        check("pause_left", left, D_SIL);
        check("pause_right", right, D_SIL);
        check("pause_busy", busy, 1);
        sample_at(q);
        check("pause_late_left", left, D_SIL);
        pulse(q, 1, 0, 0);
        sample_at(q + 1);
        check("resume_left", left, D_A4);
        check("resume_right", right, D_A5);
        sample_at(q + 13);
        check("resume_last_left", left, D_A4);
        sample_at(q + 14);
        check("resume_gap_left", left, D_SIL);
        sample_at(q + 18);
        check("pause_done_busy", busy, 0);
        sample_at(q + 20);
        end_scenario("pause");

        // Asynchronous reset in the middle of the second note
        clear_rom();
        rom[0] = mkword(1'b0, 4'd1, 6'd22, 6'd0);
        rom[1] = mkword(1'b0, 4'd3, 6'd46, 6'd34);
        p = cyc + 2;
        s = p + 3;
        strobe_q.push_back('{s, D_A4, D_SIL});
        strobe_q.push_back('{s + 12, D_A6, D_A5});
        pulse(p, 1, 0, 0);
        sample_at(s + 17);
        check("arst_pre_addr", rom_addr, 1);
        check("arst_pre_left", left, D_A6);
        #2 rst = 1;
        #1;
        check("arst_addr", rom_addr, 0);
        check("arst_left", left, D_SIL);
        check("arst_right", right, D_SIL);
        check("arst_busy", busy, 0);
        @(posedge clk);
        #1 rst = 0;
        end_scenario("arst");

        // No end flag: wrap after address 7 finishes the score
        clear_rom();
        for (int i = 0; i < LEN; i++)
            rom[i] = mkword(1'b0, 4'd1, (i % 2 == 1) ? 6'd22 : 6'd10, 6'd0);
        p = cyc + 2;
        s = p + 3;
        for (int i = 0; i < LEN; i++)
            strobe_q.push_back('{s + 12 * i, (i % 2 == 1) ? D_A4 : D_A3, D_SIL});
        done_q.push_back(s + 94);
        pulse(p, 1, 0, 0);
        sample_at(s + 93);
        check("wrap_last_addr", rom_addr, 7);
        sample_at(s + 94);
        check("wrap_addr", rom_addr, 0);
        check("wrap_busy", busy, 0);
        check("wrap_left", left, D_SIL);
        sample_at(s + 110);
        end_scenario("wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
